// File: rtl/load_use_stall_ctrl_if.sv
// Fetch/decode boundary bundle for the load-use stall controller.
// dbg_state encoding: 0 = RUN, 1 = STALL, 2 = FLUSH.
interface load_use_stall_ctrl_if #(
    parameter int INST_W = 16,
    parameter int PC_W   = 32
);
    logic              fetch_nop_LD;
    logic              flush;
    logic [INST_W-1:0] if_inst;
    logic [PC_W-1:0]   if_pc_next;
    logic              if_valid;

    logic              pc_write;
    logic              idex_bubble;
    logic [INST_W-1:0] id_inst;
    logic [PC_W-1:0]   id_pc_next;
    logic              id_valid;
    logic              stall_active;
    logic              hazard_timeout;
    logic [15:0]       stall_total;
    logic [1:0]        dbg_state;

    modport master (
        output fetch_nop_LD, flush, if_inst, if_pc_next, if_valid,
        input  pc_write, idex_bubble, id_inst, id_pc_next, id_valid,
        input  stall_active, hazard_timeout, stall_total, dbg_state
    );

    modport slave (
        input  fetch_nop_LD, flush, if_inst, if_pc_next, if_valid,
        output pc_write, idex_bubble, id_inst, id_pc_next, id_valid,
        output stall_active, hazard_timeout, stall_total, dbg_state
    );
endinterface

// File: rtl/load_use_stall_ctrl.sv
// Owns the IF/ID register: freezes it on a load-use hazard, kills it on a taken
// branch flush, and caps a stuck hazard request with a sticky watchdog.
module load_use_stall_ctrl #(
    parameter int                INST_W    = 16,
    parameter int                PC_W      = 32,
    parameter int                MAX_STALL = 2,
    parameter logic [INST_W-1:0] NOP_INST  = '0
) (
    input logic                  clk,
    input logic                  rst,
    load_use_stall_ctrl_if.slave bus
);
    localparam int              CNT_W   = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [INST_W-1:0] r_id_inst;
    logic [PC_W-1:0]   r_id_pc_next;
    logic              r_id_valid;
    logic              r_stall_active;
    logic              r_hazard_timeout;
    logic [15:0]       r_stall_total;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_hazard;
    logic w_at_cap;
    logic w_stall_eff;

    // A hazard only matters against a live IF/ID instruction; flush always wins.
    assign w_hazard    = bus.fetch_nop_LD & r_id_valid;
    assign w_at_cap    = (r_stall_cnt == MAX_CNT);
    assign w_stall_eff = w_hazard & ~bus.flush & ~w_at_cap;

    assign bus.pc_write       = ~w_stall_eff;
    assign bus.idex_bubble    = w_stall_eff | bus.flush;
    assign bus.id_inst        = r_id_inst;
    assign bus.id_pc_next     = r_id_pc_next;
    assign bus.id_valid       = r_id_valid;
    assign bus.stall_active   = r_stall_active;
    assign bus.hazard_timeout = r_hazard_timeout;
    assign bus.stall_total    = r_stall_total;
    assign bus.dbg_state      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= RUN;
            r_id_inst        <= NOP_INST;
            r_id_pc_next     <= '0;
            r_id_valid       <= 1'b0;
            r_stall_active   <= 1'b0;
            r_hazard_timeout <= 1'b0;
            r_stall_total    <= 16'h0;
            r_stall_cnt      <= '0;
        end else begin
            r_stall_active <= w_stall_eff;
            if (bus.flush) begin
                r_state      <= FLUSH;
                r_id_inst    <= NOP_INST;
                r_id_pc_next <= bus.if_pc_next;
                r_id_valid   <= 1'b0;
                r_stall_cnt  <= '0;
            end else if (w_stall_eff) begin
                r_state     <= STALL;
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                if (r_stall_total != 16'hFFFF) begin
                    r_stall_total <= r_stall_total + 16'd1;
                end
            end else begin
                // Covers both normal advance and the watchdog's forced release.
                r_state      <= RUN;
                r_id_inst    <= bus.if_inst;
                r_id_pc_next <= bus.if_pc_next;
                r_id_valid   <= bus.if_valid;
                r_stall_cnt  <= '0;
                if (w_hazard) begin
                    r_hazard_timeout <= 1'b1;
                end
            end
        end
    end
endmodule
